// File: rtl/gt_mem_responder_if.sv
// Miss-request / writeback / fill bus between the cache fill path (master)
// and the main-memory responder (slave).
interface gt_mem_responder_if;
  logic         reqValid;
  logic [31:0]  reqAddr;
  logic         reqReady;
  logic         wbValid;
  logic [31:0]  wbAddr;
  logic [255:0] wbData;
  logic         fillValid;
  logic [31:0]  fillAddr;
  logic [255:0] fillData;

  modport master (
    output reqValid, reqAddr, wbValid, wbAddr, wbData,
    input  reqReady, fillValid, fillAddr, fillData
  );

  modport slave (
    input  reqValid, reqAddr, wbValid, wbAddr, wbData,
    output reqReady, fillValid, fillAddr, fillData
  );
endinterface

// File: rtl/gt_mem_responder.sv
// Main-memory responder: fixed-latency line fills plus always-accepted writebacks.
// Optional fill/writeback statistics counters are enabled with GT_MEM_STATS_EN.
module gt_mem_responder #(
  parameter int LATENCY    = 4,
  parameter int LINES_LOG2 = 10
) (
  input  logic               CLK,
  input  logic               RST_N,
  gt_mem_responder_if.slave  bus,
  output logic [15:0]        rdCount,
  output logic [15:0]        wbCount
);
  localparam int         LINES  = 1 << LINES_LOG2;
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      stateReg, stateNext;
  logic [7:0]  cntReg, cntNext;
  logic [26:0] lineReg, lineNext;
  logic        readyReg;

  // Untouched lines read back the address pattern, so only a written flag
  // needs a power-up value; the data array itself is never initialised.
  logic [255:0] memArray [LINES];
  logic         lineWritten [LINES] = '{default: 1'b0};
  logic [255:0] rdDataReg;
  logic         rdWrittenReg;

  logic [LINES_LOG2-1:0] reqIdx, wbIdx, pendIdx, rdIdx;
  logic [255:0]          initLine, lineData;
  logic                  unusedAddrBits;

  assign reqIdx  = bus.reqAddr[LINES_LOG2+4:5];
  assign wbIdx   = bus.wbAddr[LINES_LOG2+4:5];
  assign pendIdx = lineReg[LINES_LOG2-1:0];
  assign unusedAddrBits = &{1'b0, bus.reqAddr[4:0], bus.wbAddr[4:0], bus.wbAddr[31:LINES_LOG2+5]};

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_init
      assign initLine[8*gi +: 8] = {pendIdx[2:0], 5'(gi)};
    end
  endgenerate

  // In IDLE the read port looks at the incoming request so a LATENCY=1 fill
  // has its data registered by the RESP cycle.
  assign rdIdx = (stateReg == IDLE) ? reqIdx : pendIdx;

  always_ff @(posedge CLK) begin
    if (bus.wbValid) begin
      memArray[wbIdx]    <= bus.wbData;
      lineWritten[wbIdx] <= 1'b1;
    end
    if (bus.wbValid && (wbIdx == rdIdx)) begin
      rdDataReg    <= bus.wbData;
      rdWrittenReg <= 1'b1;
    end else begin
      rdDataReg    <= memArray[rdIdx];
      rdWrittenReg <= lineWritten[rdIdx];
    end
  end

  // A writeback landing in the RESP cycle itself must win over the registered read.
  assign lineData = (bus.wbValid && (wbIdx == pendIdx)) ? bus.wbData :
                    (rdWrittenReg ? rdDataReg : initLine);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stateReg <= IDLE;
      cntReg   <= '0;
      lineReg  <= '0;
      readyReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      lineReg  <= lineNext;
      readyReg <= 1'b1;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    cntNext       = cntReg;
    lineNext      = lineReg;
    bus.reqReady  = readyReg && (stateReg == IDLE);
    bus.fillValid = 1'b0;
    bus.fillAddr  = '0;
    bus.fillData  = '0;
    case (stateReg)
      IDLE: begin
        if (bus.reqValid && readyReg) begin
          lineNext = bus.reqAddr[31:5];
          if (LATENCY == 1) begin
            stateNext = RESP;
          end else begin
            stateNext = WAIT;
            cntNext   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cntReg <= 8'd1) stateNext = RESP;
        else                cntNext   = cntReg - 8'd1;
      end
      RESP: begin
        bus.fillValid = 1'b1;
        bus.fillAddr  = {lineReg, 5'b0};
        bus.fillData  = lineData;
        stateNext     = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

`ifdef GT_MEM_STATS_EN
  logic [15:0] rdCountReg, wbCountReg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdCountReg <= '0;
      wbCountReg <= '0;
    end else begin
      if (stateReg == RESP) rdCountReg <= rdCountReg + 16'd1;
      if (bus.wbValid)      wbCountReg <= wbCountReg + 16'd1;
    end
  end

  assign rdCount = rdCountReg;
  assign wbCount = wbCountReg;
`else
  assign rdCount = '0;
  assign wbCount = '0;
`endif
endmodule

// File: tb/tb_gt_mem_responder.sv
// Bench for gt_mem_responder: LATENCY=4 and LATENCY=1 instances checked every
// cycle against a byte-array memory model, plus a vector table and corner sequences.
`timescale 1ns/1ps
module tb_gt_mem_responder;
  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  gt_mem_responder_if ifA ();
  gt_mem_responder_if ifB ();

  logic         reqValid [2];
  logic [31:0]  reqAddr  [2];
  logic         wbValid  [2];
  logic [31:0]  wbAddr   [2];
  logic [255:0] wbData   [2];
  logic         dutReady [2];
  logic         dutFill  [2];
  logic [31:0]  dutFAddr [2];
  logic [255:0] dutFData [2];
  logic [15:0]  rdA, wbA, rdB, wbB;

  assign ifA.reqValid = reqValid[0]; assign ifB.reqValid = reqValid[1];
  assign ifA.reqAddr  = reqAddr[0];  assign ifB.reqAddr  = reqAddr[1];
  assign ifA.wbValid  = wbValid[0];  assign ifB.wbValid  = wbValid[1];
  assign ifA.wbAddr   = wbAddr[0];   assign ifB.wbAddr   = wbAddr[1];
  assign ifA.wbData   = wbData[0];   assign ifB.wbData   = wbData[1];
  assign dutReady[0] = ifA.reqReady;  assign dutReady[1] = ifB.reqReady;
  assign dutFill[0]  = ifA.fillValid; assign dutFill[1]  = ifB.fillValid;
  assign dutFAddr[0] = ifA.fillAddr;  assign dutFAddr[1] = ifB.fillAddr;
  assign dutFData[0] = ifA.fillData;  assign dutFData[1] = ifB.fillData;

  gt_mem_responder #(.LATENCY(4), .LINES_LOG2(10)) dutA (
    .CLK(CLK), .RST_N(RST_N), .bus(ifA), .rdCount(rdA), .wbCount(wbA));
  gt_mem_responder #(.LATENCY(1), .LINES_LOG2(10)) dutB (
    .CLK(CLK), .RST_N(RST_N), .bus(ifB), .rdCount(rdB), .wbCount(wbB));

  // Reference model: flat byte memory (32 KiB window, aliasing by masking),
  // plus "fill is due in cycle N" bookkeeping per instance.
  logic [7:0]  mm [2][32768];
  bit          readyM [2];
  bit          pendM  [2];
  int          fillCycM [2];
  logic [31:0] pendAddrM [2];
  logic [15:0] rdExp [2], wbExp [2];
  int          cyc;

  bit           lastReady [2];
  bit           lastFill  [2];
  logic [255:0] lastData  [2];
  logic [31:0]  lastAddr  [2];
  int           lastCyc;

  int checks = 0;
  int errors = 0;

  function automatic int latOf(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic [255:0] modelLine(input int d, input logic [31:0] a);
    logic [255:0] l;
    int base;
    base = int'(a & 32'h7FE0);
    for (int k = 0; k < 32; k++) l[8*k +: 8] = mm[d][base + k];
    return l;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs are set at the falling edge; outputs checked 1ns later; model advances on the rising edge.
  task automatic step();
    #1;
    for (int d = 0; d < 2; d++) begin
      bit           f;
      logic [255:0] expData;
      logic [31:0]  expAddr;
      f = RST_N && pendM[d] && (cyc == fillCycM[d]);
      expAddr = f ? pendAddrM[d] : 32'h0;
      expData = '0;
      if (f) begin
        expData = modelLine(d, pendAddrM[d]);
        if (wbValid[d] && (((wbAddr[d] ^ pendAddrM[d]) & 32'h7FE0) == 0)) expData = wbData[d];
      end
      chk($sformatf("reqReady%0d", d), 256'(dutReady[d]), 256'(RST_N && readyM[d]));
      chk($sformatf("fillValid%0d", d), 256'(dutFill[d]), 256'(f));
      chk($sformatf("fillAddr%0d", d), 256'(dutFAddr[d]), 256'(expAddr));
      chk($sformatf("fillData%0d", d), dutFData[d], expData);
`ifdef GT_MEM_STATS_EN
      chk($sformatf("rdCount%0d", d), 256'((d == 0) ? rdA : rdB), 256'(RST_N ? rdExp[d] : 16'h0));
      chk($sformatf("wbCount%0d", d), 256'((d == 0) ? wbA : wbB), 256'(RST_N ? wbExp[d] : 16'h0));
`else
      chk($sformatf("rdCount%0d", d), 256'((d == 0) ? rdA : rdB), 256'h0);
      chk($sformatf("wbCount%0d", d), 256'((d == 0) ? wbA : wbB), 256'h0);
`endif
      lastReady[d] = dutReady[d];
      lastFill[d]  = dutFill[d];
      lastData[d]  = dutFData[d];
      lastAddr[d]  = dutFAddr[d];
      if (dutFill[d]) $display("cyc %0d dut%0d fill addr=%h byte0=%h", cyc, d, dutFAddr[d], dutFData[d][7:0]);
    end
    lastCyc = cyc;
    @(posedge CLK);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!RST_N) begin
        readyM[d] = 1'b0; pendM[d] = 1'b0; rdExp[d] = '0; wbExp[d] = '0;
      end else begin
        if (pendM[d] && (fillCycM[d] == cyc - 1)) begin
          pendM[d] = 1'b0;
          rdExp[d] = rdExp[d] + 16'd1;
        end
        if (reqValid[d] && readyM[d]) begin
          pendM[d]     = 1'b1;
          fillCycM[d]  = cyc + latOf(d) - 1;
          pendAddrM[d] = reqAddr[d] & 32'hFFFF_FFE0;
        end
        readyM[d] = !pendM[d];
        if (wbValid[d]) wbExp[d] = wbExp[d] + 16'd1;
      end
      if (wbValid[d])
        for (int k = 0; k < 32; k++) mm[d][int'(wbAddr[d] & 32'h7FE0) + k] = wbData[d][8*k +: 8];
    end
    @(negedge CLK);
  endtask

  task automatic runReq(input int d, input logic [31:0] a, output int lat,
                        output logic [255:0] data, output logic [31:0] fa);
    int readyCyc;
    readyCyc = -1; lat = -1; data = '0; fa = '0;
    reqValid[d] = 1'b1; reqAddr[d] = a;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      step();
      if (readyCyc < 0 && lastReady[d]) begin
        readyCyc = lastCyc; reqValid[d] = 1'b0;
      end else if (readyCyc >= 0 && lastFill[d]) begin
        lat = lastCyc - readyCyc; data = lastData[d]; fa = lastAddr[d];
      end
    end
    reqValid[d] = 1'b0;
    if (lat < 0) begin errors++; checks++; $display("FAIL reqTimeout: addr %h got no fill expected one", a); end
    $display("req dut%0d addr=%h -> fill %h latency %0d", d, a, fa, lat);
  endtask

  task automatic doWb(input int d, input logic [31:0] a, input logic [255:0] v);
    wbValid[d] = 1'b1; wbAddr[d] = a; wbData[d] = v;
    step();
    wbValid[d] = 1'b0;
    $display("wb dut%0d addr=%h data=%h", d, a, v[7:0]);
  endtask

  typedef struct {
    logic [31:0] reqA;
    bit          doWbPre;
    logic [31:0] wbA;
    logic [7:0]  wbB;
    logic [31:0] expA;
    logic [7:0]  expB0;
    logic [7:0]  expB31;
  } vec_t;

  vec_t         vecs [6];
  int           lat, seen, firstCyc;
  logic [255:0] data;
  logic [31:0]  fa;
  int           offs [$];
  logic [31:0]  addrs [$];

  initial begin
    vecs[0] = '{32'h0000_0040, 1'b0, 32'h0,         8'h00, 32'h0000_0040, 8'h40, 8'h5F};
    vecs[1] = '{32'h0000_009C, 1'b1, 32'h0000_0080, 8'hA5, 32'h0000_0080, 8'hA5, 8'hA5};
    vecs[2] = '{32'h1234_56E7, 1'b0, 32'h0,         8'h00, 32'h1234_56E0, 8'hE0, 8'hFF};
    vecs[3] = '{32'h0000_0080, 1'b1, 32'h0000_8080, 8'h3C, 32'h0000_0080, 8'h3C, 8'h3C};
    vecs[4] = '{32'hFFFF_FFFF, 1'b0, 32'h0,         8'h00, 32'hFFFF_FFE0, 8'hE0, 8'hFF};
    vecs[5] = '{32'h0000_7FE0, 1'b0, 32'h0,         8'h00, 32'h0000_7FE0, 8'hE0, 8'hFF};

    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 32768; a++) mm[d][a] = 8'(a);
      reqValid[d] = 1'b0; reqAddr[d] = '0; wbValid[d] = 1'b0; wbAddr[d] = '0; wbData[d] = '0;
      readyM[d] = 1'b0; pendM[d] = 1'b0; fillCycM[d] = 0; pendAddrM[d] = '0;
      rdExp[d] = '0; wbExp[d] = '0; lastReady[d] = 1'b0; lastFill[d] = 1'b0;
    end
    cyc = 0;
    @(negedge CLK);
    step(); step();
    RST_N = 1'b1;
    step(); step();

    // Vector table on the LATENCY=4 instance
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].doWbPre) doWb(0, vecs[i].wbA, {32{vecs[i].wbB}});
      runReq(0, vecs[i].reqA, lat, data, fa);
      chk($sformatf("vec%0d.lat", i), 256'(lat), 256'd4);
      chk($sformatf("vec%0d.addr", i), 256'(fa), 256'(vecs[i].expA));
      chk($sformatf("vec%0d.b0", i), 256'(data[7:0]), 256'(vecs[i].expB0));
      chk($sformatf("vec%0d.b31", i), 256'(data[255:248]), 256'(vecs[i].expB31));
    end

    // Writeback landing in the RESP cycle is bypassed into the fill
    reqValid[0] = 1'b1; reqAddr[0] = 32'h100;
    for (int i = 0; i < 20 && !(lastReady[0] && reqValid[0]); i++) step();
    reqValid[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("waitReadyLow", 256'(lastReady[0]), 256'd0);
    end
    wbValid[0] = 1'b1; wbAddr[0] = 32'h100; wbData[0] = {32{8'h11}};
    step();
    wbValid[0] = 1'b0;
    chk("respWbFill", 256'(lastFill[0]), 256'd1);
    chk("respWbData", lastData[0], {32{8'h11}});
    chk("respReadyLow", 256'(lastReady[0]), 256'd0);

    // Reset pulse during WAIT drops the transaction
    reqValid[0] = 1'b1; reqAddr[0] = 32'h60;
    for (int i = 0; i < 20 && !(lastReady[0] && reqValid[0]); i++) step();
    reqValid[0] = 1'b0;
    step();
    RST_N = 1'b0;
    #1;
    chk("rstFillValid", 256'(dutFill[0]), 256'd0);
    chk("rstReady", 256'(dutReady[0]), 256'd0);
    step(); step();
    RST_N = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (lastFill[0]) seen++;
    end
    chk("rstNoFill", 256'(seen), 256'd0);
    runReq(0, 32'h20, lat, data, fa);
    chk("postRstLat", 256'(lat), 256'd4);
    chk("postRstB0", 256'(data[7:0]), 256'h20);
    chk("postRstB31", 256'(data[255:248]), 256'h3F);

    // LATENCY=1 back-to-back held requests
    reqValid[1] = 1'b1; reqAddr[1] = 32'h0; firstCyc = -1; seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (lastFill[1]) begin offs.push_back(lastCyc - firstCyc); addrs.push_back(lastAddr[1]); end
      else if (lastData[1] != '0) seen++;
      if (lastReady[1] && reqValid[1]) begin
        if (firstCyc < 0) begin firstCyc = lastCyc; reqAddr[1] = 32'h20; end
        else reqValid[1] = 1'b0;
      end
    end
    reqValid[1] = 1'b0;
    chk("b2bFills", 256'(offs.size()), 256'd2);
    if (offs.size() == 2) begin
      chk("b2bOff0", 256'(offs[0]), 256'd1);
      chk("b2bOff1", 256'(offs[1]), 256'd3);
      chk("b2bAddr1", 256'(addrs[1]), 256'h20);
    end
    chk("b2bIdleZero", 256'(seen), 256'd0);

    // Statistics: 2 writebacks + 3 fills after a fresh reset
    RST_N = 1'b0; step(); RST_N = 1'b1; step();
    doWb(0, 32'h200, {8{32'hDEAD_BEEF}});
    doWb(0, 32'h220, {8{32'h0BAD_F00D}});
    runReq(0, 32'h200, lat, data, fa);
    chk("statsWbData", data, {8{32'hDEAD_BEEF}});
    runReq(0, 32'h220, lat, data, fa);
    runReq(0, 32'h240, lat, data, fa);
    step();
`ifdef GT_MEM_STATS_EN
    chk("statsRd", 256'(rdA), 256'd3);
    chk("statsWb", 256'(wbA), 256'd2);
`else
    chk("statsRd", 256'(rdA), 256'd0);
    chk("statsWb", 256'(wbA), 256'd0);
`endif

    // Randomized traffic on both instances, aliased addresses over 8 lines
    for (int i = 0; i < 600; i++) begin
      RST_N = ($urandom_range(0, 199) != 0);
      for (int d = 0; d < 2; d++) begin
        if (!(reqValid[d] && !lastReady[d])) begin
          reqValid[d] = ($urandom_range(0, 1) == 1);
          reqAddr[d]  = ($urandom & 32'hFFFF_8000) | (32'($urandom_range(0, 7)) << 5) | ($urandom & 32'h1F);
        end
        wbValid[d] = ($urandom_range(0, 3) == 0);
        wbAddr[d]  = ($urandom & 32'hFFFF_8000) | (32'($urandom_range(0, 7)) << 5) | ($urandom & 32'h1F);
        wbData[d]  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      step();
    end
    RST_N = 1'b1;
    for (int d = 0; d < 2; d++) begin reqValid[d] = 1'b0; wbValid[d] = 1'b0; end
    for (int i = 0; i < 8; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gt_mem_responder.md
# gt_mem_responder

Main-memory responder at the far end of the direct-mapped cache's fill path. Accepts one line-miss request at a time, waits a fixed access latency, and returns the full 256-bit line on the fill bus that the cache samples as `memData`. It also absorbs evicted lines written back from the cache/victim path into the backing array. It is the behavioural memory model for the cache-hierarchy benches and the fill sequencer for the synthesizable top.

## Interface
- `LATENCY`, 4: cycles from request acceptance to fill beat; legal 1..255
- `LINES_LOG2`, 10: log2 of lines in the backing array; line index = `addr[LINES_LOG2+4:5]`
- `CLK`  in  1  single clock, all state on rising edge
- `RST_N`  in  1  asynchronous, active-low reset
- `reqValid`  in  1  miss request present
- `reqAddr`  in  32  byte address of the miss; bits [4:0] ignored
- `reqReady`  out  1  responder can accept a request this cycle
- `wbValid`  in  1  writeback line present
- `wbAddr`  in  32  byte address of the written-back line; bits [4:0] ignored
- `wbData`  in  256  written-back line
- `fillValid`  out  1  one-cycle fill beat
- `fillAddr`  out  32  line-aligned address of the fill (`[4:0]` = 0)
- `fillData`  out  256  line data; byte k = address `fillAddr+k`, at bits [8k+7:8k]
- `rdCount`  out  16  fills issued (see Configuration)
- `wbCount`  out  16  writebacks absorbed (see Configuration)

## Operation
- Backing array: 2^LINES_LOG2 × 256 bits. Initialized at time zero so each byte equals the low 8 bits of its own byte address; not cleared by reset.
- States: IDLE, WAIT, RESP.
  - IDLE: `reqReady`=1. On `reqValid`, latch line address; go RESP if LATENCY=1, else WAIT with counter = LATENCY-1.
  - WAIT: decrement counter each cycle; go RESP when counter reaches 1.
  - RESP: assert `fillValid`, drive `fillAddr`/`fillData` from array at the latched index; return to IDLE next cycle.
- Requests outside IDLE are not accepted (`reqReady`=0); requester holds `reqValid`/`reqAddr`.
- Writebacks: always accepted (no ready); `wbValid` writes `wbData` to the array at `wbAddr` index on that edge, in any state.
- Ordering: writeback to the pending line before or in the RESP cycle is visible in the fill (RESP bypasses same-cycle `wbData` when indices match). Simultaneous `reqValid` and `wbValid` in IDLE to the same line: fill returns `wbData`.
- `fillData` and `fillAddr` are all-zero whenever `fillValid`=0; the cache treats nonzero `memData` as a fill.
- Address bits above the index are ignored (aliasing wraps).

## Timing
- Reset values: `reqReady`=0 while `RST_N` low, 1 from first edge after release; `fillValid`=0, `fillAddr`=0, `fillData`=0, counters 0; state IDLE.
- Request accepted at edge T → `fillValid` high for exactly the cycle after edge T+LATENCY-1, i.e., LATENCY cycles after acceptance. Next request acceptable the cycle after the fill beat. Back-to-back throughput: one line per LATENCY+1 cycles.
- Reset mid-WAIT or mid-RESP: transaction dropped, no fill issued, outputs zero immediately (asynchronous); array contents and already-written writebacks retained.
- Counters wrap 0xFFFF→0x0000.

## Configuration
- `GT_MEM_STATS_EN` defined: `rdCount` increments on each fill beat, `wbCount` on each accepted writeback; both reset to 0.
- Not defined: counter logic omitted; `rdCount` and `wbCount` tied to 0. No other behaviour changes.

## Test plan
- Reset then request `reqAddr`=0x00000040, LATENCY=4 → `fillValid` one cycle, 4 cycles after acceptance, `fillAddr`=0x40, byte 0=0x40, byte 31=0x5F.
- Writeback `wbAddr`=0x80, `wbData`=all 0xA5, then request 0x9C → fill of 0x80 with all bytes 0xA5.
- Request 0x100 accepted; writeback to 0x100 in the RESP cycle with data 0x11..11 → fill carries 0x11..11; `reqReady` low through WAIT/RESP.
- `RST_N` pulsed low during WAIT → no `fillValid`; next request to 0x20 fills normally with byte 0=0x20.
- LATENCY=1, requests 0x0 and 0x20 held back-to-back → fills 1 and 3 cycles after first acceptance; `fillData`=0 on non-fill cycles.
- With `GT_MEM_STATS_EN`: 3 fills + 2 writebacks → `rdCount`=3, `wbCount`=2; without it both read 0.
